// File: rtl/ysyx_22041071_rd_arbiter.sv
// Two-master (IFU/LSU) single-beat read arbiter in front of the AXI read master.
// Define YSYX_22041071_RD_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module ysyx_22041071_rd_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ifu_req_valid_i,
  output logic              ifu_req_ready_o,
  input  logic [ADDR_W-1:0] ifu_req_addr_i,
  input  logic [1:0]        ifu_req_size_i,
  output logic              ifu_resp_valid_o,
  output logic [DATA_W-1:0] ifu_resp_data_o,
  output logic [1:0]        ifu_resp_resp_o,
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic [ADDR_W-1:0] lsu_req_addr_i,
  input  logic [1:0]        lsu_req_size_i,
  output logic              lsu_resp_valid_o,
  output logic [DATA_W-1:0] lsu_resp_data_o,
  output logic [1:0]        lsu_resp_resp_o,
  output logic              rd_ar_valid_o,
  input  logic              rd_ar_ready_i,
  output logic [ID_W-1:0]   rd_id_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [LEN_W-1:0]  rd_len_o,
  output logic [1:0]        rd_size_o,
  input  logic              rd_r_valid_i,
  input  logic [DATA_W-1:0] rd_r_data_i,
  input  logic [1:0]        rd_r_resp_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                owner_q;  // 0: IFU, 1: LSU
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   ifu_data_q, lsu_data_q;
  logic [1:0]          ifu_resp_q, lsu_resp_q;
  logic                grant_ifu, grant_lsu;
  logic                idle, accept, capture;

`ifdef YSYX_22041071_RD_ARB_RR_EN
  logic last_q;  // last granted port: 0 IFU, 1 LSU

  // On a tie the port that was not granted last wins.
  always_comb begin
    grant_lsu = lsu_req_valid_i & (~ifu_req_valid_i | ~last_q);
    grant_ifu = ifu_req_valid_i & (~lsu_req_valid_i | last_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q <= 1'b0;
    end else if (accept) begin
      last_q <= grant_lsu;
    end
  end
`else
  always_comb begin
    grant_lsu = lsu_req_valid_i;
    grant_ifu = ifu_req_valid_i & ~lsu_req_valid_i;
  end
`endif

  // Ready is masked by reset so every output reads 0 while reset is held.
  assign idle    = (state_q == StIdle) & ~reset_i;
  assign accept  = idle & (grant_ifu | grant_lsu);
  assign capture = (state_q == StWait) & rd_r_valid_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: if (rd_ar_ready_i) state_d = StWait;
      StWait:  if (rd_r_valid_i) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      ifu_data_q <= '0;
      ifu_resp_q <= '0;
      lsu_data_q <= '0;
      lsu_resp_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant_lsu;
        addr_q  <= grant_lsu ? lsu_req_addr_i : ifu_req_addr_i;
        size_q  <= grant_lsu ? lsu_req_size_i : ifu_req_size_i;
      end
      if (capture) begin
        if (owner_q) begin
          lsu_data_q <= rd_r_data_i;
          lsu_resp_q <= rd_r_resp_i;
        end else begin
          ifu_data_q <= rd_r_data_i;
          ifu_resp_q <= rd_r_resp_i;
        end
      end
    end
  end

  always_comb begin
    ifu_req_ready_o  = idle & grant_ifu;
    lsu_req_ready_o  = idle & grant_lsu;
    rd_ar_valid_o    = (state_q == StIssue);
    rd_id_o          = ID_W'(owner_q);
    rd_addr_o        = addr_q;
    rd_len_o         = '0;
    rd_size_o        = size_q;
    ifu_resp_valid_o = (state_q == StResp) & ~owner_q;
    lsu_resp_valid_o = (state_q == StResp) & owner_q;
    ifu_resp_data_o  = ifu_data_q;
    ifu_resp_resp_o  = ifu_resp_q;
    lsu_resp_data_o  = lsu_data_q;
    lsu_resp_resp_o  = lsu_resp_q;
  end

endmodule

// File: doc/ysyx_22041071_rd_arbiter.md
Name: ysyx_22041071_rd_arbiter

Overview:
- Two-master read arbiter placed directly upstream of the AXI read-channel master.
- Accepts single-beat read requests from IFU (port 0) and LSU (port 1) and grants one at a time.
- Presents the granted request on the cpu-side AR interface of the AXI read master, then waits for the data beat.
- Routes the returned data and resp back to the granted requester only. One transaction is outstanding at a time.

Parameters:
- ADDR_W, 64, request address width.
- DATA_W, 64, read data width.
- ID_W, 4, AXI ID width; IFU issues ID 0, LSU issues ID 1.
- LEN_W, 8, AXI len width; always driven 0 (single beat).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  ADDR_W  IFU byte address.
- ifu_req_size  in  2  00=1B 01=2B 10=4B 11=8B.
- ifu_resp_valid  out  1  one-cycle pulse, data valid for IFU.
- ifu_resp_data  out  DATA_W  returned data.
- ifu_resp_resp  out  2  AXI resp.
- lsu_req_valid / lsu_req_ready / lsu_req_addr / lsu_req_size / lsu_resp_valid / lsu_resp_data / lsu_resp_resp: same as the IFU ports, for the LSU.
- rd_ar_valid  out  1  request to the AXI read master.
- rd_ar_ready  in  1  AXI read master can accept.
- rd_id  out  ID_W  transaction ID.
- rd_addr  out  ADDR_W  latched address.
- rd_len  out  LEN_W  constant 0.
- rd_size  out  2  latched size.
- rd_r_valid  in  1  data beat valid (one-cycle pulse per beat).
- rd_r_data  in  DATA_W  masked read data.
- rd_r_resp  in  2  AXI resp.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, owner 0, rr pointer 0.
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding).
- IDLE:
  - Arbitrate among asserted req_valid. Default policy is fixed priority, LSU over IFU.
  - Assert req_ready combinationally to the winner only.
  - On handshake, latch addr, size and owner, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - rd_ar_valid=1; rd_id/rd_addr/rd_size stay stable from the latches.
  - Go to WAIT on rd_ar_valid & rd_ar_ready. ar_valid drops the cycle after the handshake.
- WAIT:
  - On rd_r_valid, capture rd_r_data and rd_r_resp into the owner's resp registers, then go to RESP.
  - rd_r_valid in any state other than WAIT is ignored.
- RESP:
  - Owner's resp_valid=1 for exactly one cycle; the other port's resp_valid stays 0. Go to IDLE.
  - resp_data/resp_resp hold their value until the next capture.
- req_ready is 0 in every state except IDLE, so new requests stall during a transaction.
- Minimum latency: accept at cycle 0, rd_ar_valid at cycle 1, r_valid at cycle 2 at the earliest, resp_valid at cycle 3. Back-to-back accept is possible at cycle 4.
- Simultaneous IFU+LSU requests in IDLE: exactly one req_ready is asserted; the loser keeps valid high and is granted on the next IDLE visit.
- A requester dropping valid without a handshake has no effect.
- rd_addr is passed unaligned; the downstream block handles alignment and masking.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. Any beat arriving after reset release is ignored because the state is not WAIT.

Optional Feature:
- Macro: YSYX_22041071_RD_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-grant pointer updates on every accept; on a tie, the port not granted last wins.
- Undefined: fixed priority, LSU over IFU; the pointer logic is absent.

Test Plan:
- IFU only, addr=0x8000_0004, size=10, ar_ready=1, r_data=0x1122_3344_5566_7788, resp=00 -> rd_id=0, rd_addr=0x8000_0004, rd_size=10, rd_len=0. ifu_resp_valid pulses 1 cycle with that data; lsu_resp_valid stays 0.
- IFU and LSU valid together, fixed priority -> LSU granted first (rd_id=1). IFU is granted after LSU's RESP cycle. Two rd_ar_valid handshakes occur, in order LSU then IFU.
- Same as the previous case with RR_EN, repeated 4 times -> grants alternate LSU, IFU, LSU, IFU.
- ar_ready held 0 for 5 cycles -> rd_ar_valid stays 1 with a stable addr/id, both req_ready stay 0, no resp.
- rd_r_valid pulsed while in IDLE, then a legitimate beat with resp=10 -> the first pulse is ignored. The owner receives resp_resp=10 from the legitimate beat.
- reset asserted during WAIT, then a beat arrives after release -> all outputs 0 immediately, state IDLE, no resp_valid generated.
